// File: rtl/mano_mem_hs.sv
// Single-port synchronous RAM behind a req/ready handshake with WAIT_STATES extra access cycles.
// Define MANO_MEM_CLEAR_EN to zero the whole array, one word per cycle, after every reset.
module mano_mem_hs #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  if (DEPTH == 0 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "mano_mem_hs: DEPTH out of range 1..2**ADDR_W");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $fatal(1, "mano_mem_hs: WAIT_STATES out of range 0..15");
  end

`ifdef MANO_MEM_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_CLEAR} state_t;
  localparam state_t     RST_STATE = S_CLEAR;
  localparam logic       RST_READY = 1'b0;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC} state_t;
  localparam state_t     RST_STATE = S_IDLE;
  localparam logic       RST_READY = 1'b1;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                in_range;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_idx;
  logic [DATA_W-1:0]   mem_wd;
  logic                rd_en;
  logic                ready_d, rvalid_d, wack_d, err_d;

`ifdef MANO_MEM_CLEAR_EN
  logic [IDX_W-1:0]    clr_q, clr_d;
`endif

  assign in_range = {1'b0, addr_q} < DEPTH_X;

  // State register and sequencing counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
`ifdef MANO_MEM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef MANO_MEM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef MANO_MEM_CLEAR_EN
    clr_d   = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && ready) begin
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACC;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_ACC:  state_d = S_IDLE;
`ifdef MANO_MEM_CLEAR_EN
      S_CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == IDX_W'(DEPTH - 1)) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output / memory-control logic; feeds the output and RAM registers below
  always_comb begin
    ready_d  = (state_d == S_IDLE);
    rvalid_d = 1'b0;
    wack_d   = 1'b0;
    err_d    = 1'b0;
    rd_en    = 1'b0;
    mem_we   = 1'b0;
    mem_idx  = addr_q[IDX_W-1:0];
    mem_wd   = wdata_q;
    case (state_q)
      S_ACC: begin
        err_d = ~in_range;
        if (we_q) begin
          wack_d = 1'b1;
          mem_we = in_range;
        end else begin
          rvalid_d = 1'b1;
          rd_en    = 1'b1;
        end
      end
`ifdef MANO_MEM_CLEAR_EN
      S_CLEAR: begin
        mem_we  = 1'b1;
        mem_idx = clr_q;
        mem_wd  = '0;
      end
`endif
      default: ;
    endcase
  end

  // Request capture; the latched copy is what the access uses
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req && ready) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // RAM array and read-data register; a reset edge never commits a write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_idx] <= mem_wd;
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= in_range ? mem[mem_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready  <= RST_READY;
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
    end else begin
      ready  <= ready_d;
      rvalid <= rvalid_d;
      wack   <= wack_d;
      err    <= err_d;
    end
  end

endmodule

// File: tb/tb_mano_mem_hs.sv
// Bench for mano_mem_hs: four instances with different WAIT_STATES/DEPTH against an array model.
// Honours MANO_MEM_CLEAR_EN when the design is built with it.
module tb_mano_mem_hs;

  localparam int N = 4;

  function automatic int unsigned ws_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : (k == 2) ? 5 : 1;
  endfunction
  function automatic int unsigned dep_of(int k);
    return (k == 3) ? 2048 : 4096;
  endfunction

  logic          clk = 1'b0;
  logic [N-1:0]  rst, req;
  logic          we;
  logic [11:0]   addr;
  logic [15:0]   wdata;
  logic          ready [N];
  logic          rvalid [N];
  logic          wack [N];
  logic          err [N];
  logic [15:0]   rdata [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mano_mem_hs #(
      .DATA_W(16), .ADDR_W(12), .DEPTH(dep_of(g)), .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk(clk), .rst(rst[g]), .req(req[g]), .we(we), .addr(addr), .wdata(wdata),
      .ready(ready[g]), .rdata(rdata[g]), .rvalid(rvalid[g]), .wack(wack[g]), .err(err[g])
    );
  end

  logic [15:0] mdl [N][4096];
  logic [15:0] last_rd [N];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // Called at a negedge; pulses rst for one edge and checks the post-reset state.
  task automatic reset_dut(input int k);
    int n;
    rst[k] = 1'b1;
    req[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b0;
    chk("rst_rvalid", k, 32'(rvalid[k]), 0);
    chk("rst_wack",   k, 32'(wack[k]),   0);
    chk("rst_err",    k, 32'(err[k]),    0);
    chk("rst_rdata",  k, 32'(rdata[k]),  0);
    last_rd[k] = '0;
`ifdef MANO_MEM_CLEAR_EN
    n = 0;
    while (!ready[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_len", k, 32'(n), 32'(dep_of(k)));
    for (int i = 0; i < 4096; i++) mdl[k][i] = '0;
`else
    n = 0;
    chk("rst_ready", k, 32'(ready[k]), 1);
`endif
  endtask

  // Called at a negedge; issues one access and checks every cycle up to its completion pulse.
  task automatic op(input int k, input bit w, input logic [11:0] a, input logic [15:0] d,
                    input bit hold, output logic [15:0] rd, output int waited);
    int unsigned ws;
    bit inr;
    ws = ws_of(k);
    inr = (int'(a) < int'(dep_of(k)));
    we = w; addr = a; wdata = d; req[k] = 1'b1;
    waited = 0;
    rd = '0;
    while (!ready[k] && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready[k]) begin
      chk("accept_timeout", k, 32'(ready[k]), 1);
      req[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      req[k] = 1'b0;
      we = 1'($urandom); addr = 12'($urandom); wdata = 16'($urandom);
    end
    for (int n = 0; n <= int'(ws); n++) begin
      if (n > 0) @(negedge clk);
      chk("busy_ready",  k, 32'(ready[k]),  0);
      chk("busy_rvalid", k, 32'(rvalid[k]), 0);
      chk("busy_wack",   k, 32'(wack[k]),   0);
    end
    @(negedge clk);
    chk("done_ready",  k, 32'(ready[k]),  1);
    chk("done_rvalid", k, 32'(rvalid[k]), w ? 0 : 1);
    chk("done_wack",   k, 32'(wack[k]),   w ? 1 : 0);
    chk("done_err",    k, 32'(err[k]),    inr ? 0 : 1);
    if (w) begin
      if (inr) mdl[k][a] = d;
    end else begin
      last_rd[k] = inr ? mdl[k][a] : 16'h0000;
    end
    chk("rdata", k, 32'(rdata[k]), 32'(last_rd[k]));
    rd = rdata[k];
    if (!hold) begin
      @(negedge clk);
      chk("pulse_rvalid", k, 32'(rvalid[k]), 0);
      chk("pulse_wack",   k, 32'(wack[k]),   0);
      chk("pulse_err",    k, 32'(err[k]),    0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int          wt;
    logic [11:0] a;

    rst = '1; req = '0; we = 1'b0; addr = '0; wdata = '0;
    for (int k = 0; k < N; k++) begin
      last_rd[k] = '0;
      for (int i = 0; i < 4096; i++) mdl[k][i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = '0;
    for (int k = 0; k < N; k++) reset_dut(k);

    // Zero wait states: write then read back
    op(0, 1'b1, 12'h005, 16'h1234, 1'b0, rd, wt);
    op(0, 1'b0, 12'h005, 16'h0000, 1'b0, rd, wt);
    chk("ws0_read", 0, 32'(rd), 32'h1234);

    // Three wait states at the top address
    op(1, 1'b1, 12'hFFF, 16'hBEEF, 1'b0, rd, wt);
    op(1, 1'b0, 12'hFFF, 16'h0000, 1'b0, rd, wt);
    chk("ws3_read", 1, 32'(rd), 32'hBEEF);

    // Reduced depth: out-of-range write must not alias onto 0x100
    op(3, 1'b1, 12'h100, 16'h1111, 1'b0, rd, wt);
    op(3, 1'b1, 12'h900, 16'hAAAA, 1'b0, rd, wt);
    op(3, 1'b0, 12'h100, 16'h0000, 1'b0, rd, wt);
    chk("alias_read", 3, 32'(rd), 32'h1111);
    op(3, 1'b0, 12'h900, 16'h0000, 1'b0, rd, wt);
    chk("oor_read", 3, 32'(rd), 32'h0000);

    // Back-to-back reads with req held high
    for (int i = 0; i < 4; i++) op(0, 1'b1, 12'(i), 16'(i + 1), 1'b0, rd, wt);
    for (int i = 0; i < 4; i++) begin
      op(0, 1'b0, 12'(i), 16'h0000, (i < 3), rd, wt);
      chk("b2b_data", 0, 32'(rd), 32'(i + 1));
      if (i > 0) chk("b2b_wait", 0, 32'(wt), 0);
    end

    // Reset in the second wait cycle of a write abandons it
    op(2, 1'b1, 12'h010, 16'h0101, 1'b0, rd, wt);
    we = 1'b1; addr = 12'h010; wdata = 16'h7777; req[2] = 1'b1;
    wt = 0;
    while (!ready[2] && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    chk("rst_accept", 2, 32'(ready[2]), 1);
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    reset_dut(2);
    for (int i = 0; i < 8; i++) begin
      chk("abandon_wack", 2, 32'(wack[2]), 0);
      @(negedge clk);
    end
    op(2, 1'b0, 12'h010, 16'h0000, 1'b0, rd, wt);
`ifdef MANO_MEM_CLEAR_EN
    chk("abandon_read", 2, 32'(rd), 32'h0000);
`else
    chk("abandon_read", 2, 32'(rd), 32'h0101);
`endif

    // Reset with a preloaded word
    op(0, 1'b1, 12'h00A, 16'h5555, 1'b0, rd, wt);
    reset_dut(0);
    op(0, 1'b0, 12'h00A, 16'h0000, 1'b0, rd, wt);
`ifdef MANO_MEM_CLEAR_EN
    chk("clear_read", 0, 32'(rd), 32'h0000);
`else
    chk("keep_read", 0, 32'(rd), 32'h5555);
`endif

    // Random traffic on every instance
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 30; i++) begin
        a = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
        op(k, 1'($urandom), a, 16'($urandom), 1'($urandom), rd, wt);
      end
      req[k] = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
